// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the boot source and the instruction-memory loader.
// The source drives valid/data; the loader answers with ready.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles streamed bytes into instruction words, writes them to imem,
// verifies a trailing additive checksum and holds the core in reset until that passes.
module imem_loader #(
  parameter int ADDR_W     = 12,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_load_len,
  imem_loader_if.slave      byte_if,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loaderState_t;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  loaderState_t r_state;
  loaderState_t w_stateNext;

  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_wordIdx;
  logic [31:0]     r_sum;
  logic [31:0]     r_asm;
  logic [1:0]      r_byteCnt;

  logic            w_fire;
  logic            w_lastByte;
  logic            w_startAcc;
  logic [ADDR_W:0] w_lenClamp;
  logic [ADDR_W:0] w_idxNext;
  logic [31:0]     w_word;

  assign w_fire     = byte_if.byte_valid && byte_if.byte_ready;
  assign w_lastByte = w_fire && (r_byteCnt == 2'd3);
  assign w_startAcc = i_start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
  assign w_lenClamp = (i_load_len > LEN_MAX) ? LEN_MAX : i_load_len;
  assign w_idxNext  = r_wordIdx + IDX_ONE;

  // The shift direction decides where the first byte ends up after four bytes.
  assign w_word = BIG_ENDIAN ? {r_asm[23:0], byte_if.byte_data}
                             : {byte_if.byte_data, r_asm[31:8]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (w_startAcc) begin
          w_stateNext = (w_lenClamp == '0) ? CHECK : LOAD;
        end
      end
      LOAD: begin
        if (w_lastByte && (w_idxNext == r_len)) begin
          w_stateNext = CHECK;
        end
      end
      CHECK: begin
        if (w_lastByte) begin
          w_stateNext = (w_word == r_sum) ? DONE : ERROR;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    byte_if.byte_ready = (r_state == LOAD) || (r_state == CHECK);
    o_busy             = (r_state == LOAD) || (r_state == CHECK);
    o_done             = (r_state == DONE);
    o_err              = (r_state == ERROR);
    o_cpu_rst          = (r_state != DONE);
  end

  // Datapath: byte assembly, checksum accumulation and the registered imem write port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len        <= '0;
      r_wordIdx    <= '0;
      r_sum        <= '0;
      r_asm        <= '0;
      r_byteCnt    <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
    end else begin
      o_imem_we <= 1'b0;
      if (w_startAcc) begin
        r_len     <= w_lenClamp;
        r_wordIdx <= '0;
        r_sum     <= '0;
        r_byteCnt <= '0;
      end else if (w_fire) begin
        r_asm     <= w_word;
        r_byteCnt <= r_byteCnt + 2'd1;
        if (w_lastByte && (r_state == LOAD)) begin
          o_imem_we    <= 1'b1;
          o_imem_addr  <= r_wordIdx[ADDR_W-1:0];
          o_imem_wdata <= w_word;
          r_sum        <= r_sum + w_word;
          r_wordIdx    <= w_idxNext;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: normal load, bad checksum, empty image,
// stalled stream, ignored start, and asynchronous reset in the middle of a load.
module tb_imem_loader;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   loadLen;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemWdata;
  logic              cpuRst;
  logic              busy;
  logic              done;
  logic              err;

  int testCount;
  int failCount;
  int readyDrop;

  logic [ADDR_W-1:0] wrAddr[$];
  logic [31:0]       wrData[$];

  imem_loader_if byteIf ();

  imem_loader #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_load_len   (loadLen),
    .byte_if      (byteIf.slave),
    .o_imem_we    (imemWe),
    .o_imem_addr  (imemAddr),
    .o_imem_wdata (imemWdata),
    .o_cpu_rst    (cpuRst),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each negedge spent with the strobe high logs one write, so a stretched strobe shows up as an extra entry.
  always @(negedge clk) begin
    if (rst_n && imemWe) begin
      wrAddr.push_back(imemAddr);
      wrData.push_back(imemWdata);
    end
    if (rst_n && busy && !byteIf.byte_ready) readyDrop++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    byteIf.byte_valid = 1'b1;
    byteIf.byte_data  = b;
    while (!byteIf.byte_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!byteIf.byte_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 byteIf.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // mode 0: back-to-back bytes; mode 1: random gaps plus a 3-cycle stall after the second byte.
  task automatic sendWord(input logic [31:0] w, input int mode);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (mode == 0) ? 0 : ((i == 1) ? 3 : int'($urandom_range(0, 2)));
      applyStimulus(tmp[31:24], g);
      tmp = tmp << 8;
    end
  endtask

  task automatic pulseStart(input logic [ADDR_W:0] len);
    @(negedge clk);
    start   = 1'b1;
    loadLen = len;
    @(posedge clk);
    #1 start = 1'b0;
    loadLen  = '0;
  endtask

  task automatic waitFinish();
    int cyc;
    cyc = 0;
    while (!(done || err) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!(done || err)) checkOutput("finish_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
  endtask

  task automatic checkTwoWrites(input string tag);
    checkOutput({tag, "_wrcount"}, wrData.size(), 32'd2);
    checkOutput({tag, "_addr0"}, (wrAddr.size() > 0) ? 32'(wrAddr[0]) : 32'hFFFF_FFFF, 32'd0);
    checkOutput({tag, "_data0"}, (wrData.size() > 0) ? wrData[0] : 32'hFFFF_FFFF, 32'h2008_0005);
    checkOutput({tag, "_addr1"}, (wrAddr.size() > 1) ? 32'(wrAddr[1]) : 32'hFFFF_FFFF, 32'd1);
    checkOutput({tag, "_data1"}, (wrData.size() > 1) ? wrData[1] : 32'hFFFF_FFFF, 32'h2009_0007);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cpurst"}, 32'(cpuRst), 32'd1);
    checkOutput({tag, "_we"}, 32'(imemWe), 32'd0);
    checkOutput({tag, "_addr"}, 32'(imemAddr), 32'd0);
    checkOutput({tag, "_wdata"}, imemWdata, 32'd0);
    checkOutput({tag, "_ready"}, 32'(byteIf.byte_ready), 32'd0);
    checkOutput({tag, "_flags"}, {29'd0, busy, done, err}, 32'd0);
  endtask

  initial begin
    testCount          = 0;
    failCount          = 0;
    readyDrop          = 0;
    rst_n              = 1'b0;
    start              = 1'b0;
    loadLen            = '0;
    byteIf.byte_valid  = 1'b0;
    byteIf.byte_data   = 8'h00;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Normal two-word image with a correct checksum.
    clearLog();
    pulseStart(13'd2);
    @(negedge clk);
    checkOutput("s1_busy", {30'd0, busy, byteIf.byte_ready}, 32'd3);
    sendWord(32'h2008_0005, 0);
    sendWord(32'h2009_0007, 0);
    sendWord(32'h4011_000C, 0);
    waitFinish();
    checkOutput("s1_status", {29'd0, done, err, cpuRst}, 32'b100);
    checkTwoWrites("s1");
    checkOutput("s1_hold", imemWdata, 32'h2009_0007);

    // Restart from DONE: core reset must come back with the accepting edge; bad checksum follows.
    clearLog();
    pulseStart(13'd2);
    checkOutput("s2_cpurst_rise", 32'(cpuRst), 32'd1);
    sendWord(32'h2008_0005, 0);
    sendWord(32'h2009_0007, 0);
    sendWord(32'h0000_0000, 0);
    waitFinish();
    checkOutput("s2_status", {29'd0, done, err, cpuRst}, 32'b011);
    checkTwoWrites("s2");

    // Empty image: only the checksum word, which must equal zero.
    clearLog();
    pulseStart(13'd0);
    sendWord(32'h0000_0000, 0);
    waitFinish();
    checkOutput("s3_status", {29'd0, done, err, cpuRst}, 32'b100);
    checkOutput("s3_wrcount", wrData.size(), 32'd0);
    pulseStart(13'd0);
    sendWord(32'h0000_0001, 0);
    waitFinish();
    checkOutput("s3b_status", {29'd0, done, err, cpuRst}, 32'b011);
    checkOutput("s3b_wrcount", wrData.size(), 32'd0);

    // Irregular stream with stalls inside words; ready must never drop while busy.
    clearLog();
    readyDrop = 0;
    pulseStart(13'd2);
    sendWord(32'h2008_0005, 1);
    sendWord(32'h2009_0007, 1);
    sendWord(32'h4011_000C, 1);
    waitFinish();
    checkOutput("s4_status", {29'd0, done, err, cpuRst}, 32'b100);
    checkTwoWrites("s4");
    checkOutput("s4_ready_drop", readyDrop, 32'd0);

    // A start during LOAD must not change the length or restart the load.
    clearLog();
    pulseStart(13'd2);
    sendWord(32'h2008_0005, 0);
    pulseStart(13'd5);
    sendWord(32'h2009_0007, 0);
    sendWord(32'h4011_000C, 0);
    waitFinish();
    checkOutput("s5_status", {29'd0, done, err, cpuRst}, 32'b100);
    checkTwoWrites("s5");

    // Asynchronous reset after six bytes, then a full reload.
    clearLog();
    pulseStart(13'd2);
    sendWord(32'h2008_0005, 0);
    applyStimulus(8'h20, 0);
    applyStimulus(8'h09, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("s6_midreset");
    checkOutput("s6_wrcount", wrData.size(), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clearLog();
    pulseStart(13'd2);
    sendWord(32'h2008_0005, 0);
    sendWord(32'h2009_0007, 0);
    sendWord(32'h4011_000C, 0);
    waitFinish();
    checkOutput("s6_status", {29'd0, done, err, cpuRst}, 32'b100);
    checkTwoWrites("s6");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
